// File: rtl/mem_byte_sequencer.sv
// Byte-serial load/store sequencer: splits RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW into single-byte memory cycles.
// Optional macro MISALIGN_TRAP_EN: misaligned halfword/word requests complete at once with rsp_err=1.
module mem_byte_sequencer #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [2:0]        req_f3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_done,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_re,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              write_q, write_d;
    logic              err_q, err_d;
    logic [2:0]        f3_q, f3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       asm_q, asm_d;

    logic is_wr, is_rd, legal, trap;

    function automatic logic [1:0] last_idx(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   last_idx = 2'd0;
            2'b01:   last_idx = 2'd1;
            default: last_idx = 2'd3;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] a);
        case (f3)
            3'b000:  load_ext = {{24{a[7]}}, a[7:0]};
            3'b001:  load_ext = {{16{a[15]}}, a[15:0]};
            3'b100:  load_ext = {24'd0, a[7:0]};
            3'b101:  load_ext = {16'd0, a[15:0]};
            default: load_ext = a;
        endcase
    endfunction

    // Store wins over load; unsigned loads have no store counterpart.
    assign is_wr = req_write;
    assign is_rd = req_read & ~req_write;
    always_comb begin
        legal = 1'b0;
        if (is_wr)
            legal = (req_f3 == 3'b000) || (req_f3 == 3'b001) || (req_f3 == 3'b010);
        else if (is_rd)
            legal = (req_f3 == 3'b000) || (req_f3 == 3'b001) || (req_f3 == 3'b010) ||
                    (req_f3 == 3'b100) || (req_f3 == 3'b101);
    end

`ifdef MISALIGN_TRAP_EN
    assign trap = legal & (((req_f3[1:0] == 2'b01) && req_addr[0]) ||
                           ((req_f3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)));
`else
    assign trap = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            err_q   <= err_d;
        end
    end

    // Datapath holding registers; only observed through state-gated outputs.
    always_ff @(posedge clk) begin
        f3_q    <= f3_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        asm_q   <= asm_d;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        write_d   = write_q;
        err_d     = err_q;
        f3_d      = f3_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        asm_d     = asm_q;
        req_ready = 1'b0;
        rsp_done  = 1'b0;
        rsp_rdata = 32'd0;
        rsp_err   = 1'b0;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_wdata = 8'd0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    f3_d    = req_f3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    asm_d   = 32'd0;
                    write_d = is_wr;
                    cnt_d   = 2'd0;
                    err_d   = trap;
                    state_d = (legal && !trap) ? S_ACCESS : S_DONE;
                end
            end
            S_ACCESS: begin
                mem_addr = addr_q + ADDR_W'(cnt_q);
                if (write_q) begin
                    mem_we    = 1'b1;
                    mem_wdata = wdata_q[8*cnt_q +: 8];
                end else begin
                    mem_re = 1'b1;
                    asm_d[8*cnt_q +: 8] = mem_rdata;
                end
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == last_idx(f3_q))
                    state_d = S_DONE;
            end
            S_DONE: begin
                rsp_done  = 1'b1;
                rsp_rdata = write_q ? 32'd0 : load_ext(f3_q, asm_q);
                rsp_err   = err_q;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_byte_sequencer.sv
// Directed bench for mem_byte_sequencer with a 64-byte combinational-read memory model.
module tb_mem_byte_sequencer;

    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid, req_ready, req_read, req_write;
    logic [2:0]        req_f3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_done, rsp_err, busy;
    logic [31:0]       rsp_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we, mem_re;
    logic [7:0]        mem_wdata, mem_rdata;

    logic [7:0] mem [64];

    int total = 0;
    int bad   = 0;

    int          lat, nwe, nre, nrdy;
    logic [31:0] rd;
    logic        er;
    logic [ADDR_W-1:0] wa [4];
    logic [7:0]        wd [4];

    mem_byte_sequencer #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_read(req_read), .req_write(req_write),
        .req_f3(req_f3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_done(rsp_done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .busy(busy),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic start_req(input bit w, input bit r, input logic [2:0] f3,
                             input logic [ADDR_W-1:0] a, input logic [31:0] d);
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_read = r;
        req_f3 = f3; req_addr = a; req_wdata = d;
        for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
        chk("accept", 32'(req_ready), 32'd1);
        @(posedge clk);
    endtask

    task automatic wait_done(input bit keep);
        lat = 0; nwe = 0; nre = 0; nrdy = 0; rd = 32'd0; er = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1 && !keep) req_valid = 1'b0;
            if (req_ready) nrdy++;
            if (mem_we) begin
                if (nwe < 4) begin wa[nwe] = mem_addr; wd[nwe] = mem_wdata; end
                nwe++;
            end
            if (mem_re) nre++;
            if (rsp_done) begin
                lat = k; rd = rsp_rdata; er = rsp_err;
                break;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_busy"},  32'(busy), 32'd0);
        chk({tag, "_done"},  32'(rsp_done), 32'd0);
        chk({tag, "_rdata"}, rsp_rdata, 32'd0);
        chk({tag, "_err"},   32'(rsp_err), 32'd0);
        chk({tag, "_strb"},  {30'd0, mem_we, mem_re}, 32'd0);
        chk({tag, "_maddr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
    endtask

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
        req_f3 = 3'd0; req_addr = '0; req_wdata = 32'd0;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b1;

        // SW 0x8899AABB at 8, little-endian byte order
        start_req(1'b1, 1'b0, 3'b010, 6'd8, 32'h8899AABB);
        wait_done(1'b0);
        chk("sw8_lat", 32'(lat), 32'd5);
        chk("sw8_nwe", 32'(nwe), 32'd4);
        chk("sw8_nre", 32'(nre), 32'd0);
        chk("sw8_addr", {2'b0, wa[0], 2'b0, wa[1], 2'b0, wa[2], 2'b0, wa[3]}, 32'h08090A0B);
        chk("sw8_data", {wd[0], wd[1], wd[2], wd[3]}, 32'hBBAA9988);
        chk("sw8_rdata", rd, 32'd0);
        chk("sw8_err", 32'(er), 32'd0);
        @(negedge clk);
        chk("b2b_ready", 32'(req_ready), 32'd1);

        start_req(1'b0, 1'b1, 3'b010, 6'd8, 32'd0);
        wait_done(1'b0);
        chk("lw8_lat", 32'(lat), 32'd5);
        chk("lw8_rdata", rd, 32'h8899AABB);
        chk("lw8_nre", 32'(nre), 32'd4);
        chk("lw8_nwe", 32'(nwe), 32'd0);

        // [20]=0x80, [21]=0xFF, then the four narrow load flavours
        start_req(1'b1, 1'b0, 3'b001, 6'd20, 32'h1234FF80);
        wait_done(1'b0);
        chk("sh20_lat", 32'(lat), 32'd3);
        chk("sh20_nwe", 32'(nwe), 32'd2);
        start_req(1'b0, 1'b1, 3'b001, 6'd20, 32'd0);
        wait_done(1'b0);
        chk("lh_lat", 32'(lat), 32'd3);
        chk("lh_rdata", rd, 32'hFFFFFF80);
        start_req(1'b0, 1'b1, 3'b101, 6'd20, 32'd0);
        wait_done(1'b0);
        chk("lhu_rdata", rd, 32'h0000FF80);
        start_req(1'b0, 1'b1, 3'b000, 6'd20, 32'd0);
        wait_done(1'b0);
        chk("lb_lat", 32'(lat), 32'd2);
        chk("lb_rdata", rd, 32'hFFFFFF80);
        start_req(1'b0, 1'b1, 3'b100, 6'd20, 32'd0);
        wait_done(1'b0);
        chk("lbu_rdata", rd, 32'h00000080);
        // both strobes requested: store wins
        start_req(1'b1, 1'b1, 3'b000, 6'd21, 32'h0000007F);
        wait_done(1'b0);
        chk("rw_nwe", 32'(nwe), 32'd1);
        chk("rw_nre", 32'(nre), 32'd0);

        // Misaligned word at the top of memory
        start_req(1'b1, 1'b0, 3'b010, 6'd62, 32'h44332211);
        wait_done(1'b0);
`ifdef MISALIGN_TRAP_EN
        chk("sw62_lat", 32'(lat), 32'd1);
        chk("sw62_nwe", 32'(nwe), 32'd0);
        chk("sw62_err", 32'(er), 32'd1);
        chk("sw62_rdata", rd, 32'd0);
`else
        chk("sw62_lat", 32'(lat), 32'd5);
        chk("sw62_addr", {2'b0, wa[0], 2'b0, wa[1], 2'b0, wa[2], 2'b0, wa[3]}, 32'h3E3F0001);
        chk("sw62_err", 32'(er), 32'd0);
        start_req(1'b0, 1'b1, 3'b010, 6'd62, 32'd0);
        wait_done(1'b0);
        chk("lw62_rdata", rd, 32'h44332211);
`endif

        // Reset in the middle of a store: only the first byte lands
        start_req(1'b1, 1'b0, 3'b010, 6'd4, 32'hEEEEEEEE);
        wait_done(1'b0);
        start_req(1'b1, 1'b0, 3'b010, 6'd4, 32'h44332211);
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort_c1_addr", {26'd0, mem_addr}, 32'd4);
        @(negedge clk);
        chk("abort_c2_addr", {26'd0, mem_addr}, 32'd5);
        rst = 1'b0;
        #1;
        check_reset_outputs("abort");
        nrdy = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rsp_done) nrdy++;
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rsp_done) nrdy++;
        end
        chk("abort_no_done", 32'(nrdy), 32'd0);
        chk("abort_mem", {mem[4], mem[5], mem[6], mem[7]}, 32'h11EEEEEE);
        start_req(1'b0, 1'b1, 3'b010, 6'd4, 32'd0);
        wait_done(1'b0);
        chk("abort_lw4", rd, 32'hEEEEEE11);

        // Illegal encodings finish in one cycle with no memory traffic
        start_req(1'b0, 1'b1, 3'b011, 6'd8, 32'd0);
        wait_done(1'b0);
        chk("ill_lat", 32'(lat), 32'd1);
        chk("ill_rdata", rd, 32'd0);
        chk("ill_strb", 32'(nwe + nre), 32'd0);
        chk("ill_err", 32'(er), 32'd0);
        start_req(1'b1, 1'b0, 3'b100, 6'd8, 32'hFFFFFFFF);
        wait_done(1'b0);
        chk("ill_sbu_lat", 32'(lat), 32'd1);
        chk("ill_sbu_nwe", 32'(nwe), 32'd0);
        start_req(1'b0, 1'b0, 3'b000, 6'd8, 32'd0);
        wait_done(1'b0);
        chk("norw_lat", 32'(lat), 32'd1);
        chk("norw_strb", 32'(nwe + nre), 32'd0);

        // Request held while busy; inputs change after acceptance
        start_req(1'b0, 1'b1, 3'b010, 6'd8, 32'd0);
        #1;
        req_f3 = 3'b100; req_addr = 6'd20;
        wait_done(1'b1);
        chk("busy_lw_lat", 32'(lat), 32'd5);
        chk("busy_lw_rdata", rd, 32'h8899AABB);
        chk("busy_not_ready", 32'(nrdy), 32'd0);
        start_req(1'b0, 1'b1, 3'b100, 6'd20, 32'd0);
        wait_done(1'b0);
        chk("busy_lbu_lat", 32'(lat), 32'd2);
        chk("busy_lbu_rdata", rd, 32'h00000080);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_byte_sequencer.md
# mem_byte_sequencer

Multi-cycle load/store sequencer between the MEM-stage pipeline register and a byte-wide (8-bit) data memory port. It accepts one load/store request, encoded with RISC-V funct3, and serialises it into 1, 2 or 4 single-byte memory cycles. It then returns sign- or zero-extended load data with a one-cycle completion pulse, and asserts `busy` so the hazard unit can stall the pipeline.

## Interface
Parameters:
- `ADDR_W`, 6, byte address width; the memory is 2^ADDR_W bytes and addresses wrap modulo 2^ADDR_W.

Ports:
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request; high only in IDLE.
- `req_read` in 1: load request.
- `req_write` in 1: store request; has priority over `req_read` if both are set.
- `req_f3` in 3: funct3 (LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101).
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in 32: store data; low bytes are used.
- `rsp_done` out 1: one-cycle completion pulse.
- `rsp_rdata` out 32: extended load data; valid while `rsp_done`=1, otherwise 0.
- `rsp_err` out 1: misaligned-access flag, qualified by `rsp_done`.
- `busy` out 1: state ≠ IDLE.
- `mem_addr` out ADDR_W: byte address to memory.
- `mem_we` out 1: byte write strobe.
- `mem_re` out 1: byte read strobe.
- `mem_wdata` out 8: byte to write.
- `mem_rdata` in 8: byte read data; combinational from `mem_addr`.

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE → ACCESS on `req_valid`=1 with (`req_read` | `req_write`) and a legal F3.
  - Latch address, F3, write data and direction.
  - Byte count N: 1 for 000/100, 2 for 001/101, 4 for 010.
  - Clear byte counter `cnt`.
- IDLE → DONE directly, with no memory activity, in two cases:
  - `req_valid` with illegal F3 (011, 110, 111): `rsp_rdata`=0, `rsp_err`=0.
  - `req_valid` with neither read nor write: same response.
  - Stores with F3 100/101 are also illegal and take this path.
- ACCESS: each cycle drives `mem_addr`=(addr+cnt) mod 2^ADDR_W.
  - Store: `mem_we`=1, `mem_wdata`=`req_wdata`[8·cnt+7:8·cnt].
  - Load: `mem_re`=1; `mem_rdata` is captured into byte `cnt` of the assembly register at the clock edge.
  - `cnt` increments each cycle. When `cnt`=N−1, go to DONE.
- DONE: `rsp_done`=1 for exactly one cycle, then → IDLE.
  - Loads: `rsp_rdata` is the assembled value, sign-extended from bit 7/15 for 000/001 and zero-extended for 100/101; LW is used unextended.
  - Stores: `rsp_rdata`=0.
- Memory strobes are 0 outside ACCESS. `mem_addr` and `mem_wdata` are 0 outside ACCESS.
- Byte order is little-endian: byte 0 is at the lowest address.
- Reset asserted mid-operation: immediate return to IDLE. Bytes already written stay in memory; no `rsp_done` is issued for the aborted request.

## Timing
- Reset values: `req_ready`=1, `busy`=0, `rsp_done`=0, `rsp_rdata`=0, `rsp_err`=0, `mem_we`=0, `mem_re`=0, `mem_addr`=0, `mem_wdata`=0.
- Request accepted at edge T. Memory cycles occupy T+1 … T+N. `rsp_done` is high in cycle T+N+1. `req_ready` is high again in cycle T+N+2.
- Latency: LB/SB 2 cycles, LH/SH 3 cycles, LW/SW 5 cycles, from acceptance to `rsp_done`.
- Requests arriving while `req_ready`=0 are ignored; the requester must hold `req_valid` until acceptance.
- Back-to-back requests: a new request can be accepted in the cycle after DONE.
- Request inputs are sampled only at acceptance; later changes have no effect.

## Configuration
- `MISALIGN_TRAP_EN` defined:
  - Halfword with addr[0]=1, or word with addr[1:0]≠0, goes IDLE → DONE with no memory activity.
  - Response: `rsp_err`=1, `rsp_rdata`=0.
- `MISALIGN_TRAP_EN` undefined:
  - Misaligned accesses proceed byte-serially, wrapping modulo 2^ADDR_W.
  - `rsp_err` is tied to 0.

## Test plan
- SW `req_addr`=8, `req_wdata`=0x8899AABB, then LW at 8:
  - Bytes 0xBB, 0xAA, 0x99, 0x88 are written to addresses 8–11 in cycles T+1…T+4.
  - LW returns `rsp_rdata`=0x8899AABB with `rsp_done` at acceptance+5.
- Memory bytes [20]=0x80 and [21]=0xFF, then LH, LHU, LB, LBU at address 20:
  - LH returns 0xFFFFFF80 (address 20 is the low byte).
  - LHU returns 0x0000FF80.
  - LB returns 0xFFFFFF80.
  - LBU returns 0x00000080.
- SW at address 62 with macro undefined:
  - Bytes go to addresses 62, 63, 0, 1.
  - `rsp_err`=0.
- SW at address 62 with macro defined:
  - No `mem_we` pulses.
  - `rsp_done` at acceptance+1 with `rsp_err`=1.
- `rst` asserted low during cycle T+2 of an SW to address 4:
  - Outputs return to reset values immediately.
  - Only address 4 is modified.
  - No `rsp_done` is issued.
- Illegal F3=011 load, and `req_valid` raised while `busy`=1:
  - The illegal load completes in 1 cycle with `rsp_rdata`=0 and no strobes.
  - The request raised while busy is not accepted until `req_ready`=1.
